uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters (fixed at 4 in this version).
REQ-002 SHALL have parameter DATA_W, default 8, the byte width passed to the UART.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, width NUM_REQ: per-requester transmit request, held high until ack.
REQ-006 SHALL have port req_data, input, width NUM_REQ*DATA_W: requester i's byte in bits [i*8+7:i*8].
REQ-007 SHALL have port req_psel, input, width NUM_REQ: per-requester parity select, forwarded to the UART.
REQ-008 SHALL have port ack, output, width NUM_REQ: one-cycle pulse meaning the requester's byte was consumed.
REQ-009 SHALL have port uart_send, output, width 1: one-cycle transmit strobe to the UART.
REQ-010 SHALL have port uart_d_in, output, width DATA_W: the latched byte presented to the UART.
REQ-011 SHALL have port uart_p_sel, output, width 1: the latched parity select.
REQ-012 SHALL have port uart_busy, input, width 1: high while the UART is shifting a frame.
REQ-013 SHALL have port grant_id, output, width 2: index of the current or most recent winner.
REQ-014 SHALL have port active, output, width 1: high in every state except IDLE.
REQ-015 SHALL have port start_err, output, width 1: one-cycle pulse when the UART fails to go busy.

Function
REQ-016 SHALL implement a four-state FSM with states IDLE, SEND, WAIT_BUSY and WAIT_IDLE.
REQ-017 SHALL, in IDLE with any req bit high, pick a winner round-robin starting at last_grant+1 (mod 4).
REQ-018 SHALL, on that IDLE edge, latch the winner's byte, psel and index into uart_d_in, uart_p_sel and grant_id, then move to SEND.
REQ-019 SHALL, in SEND, drive uart_send=1 and ack[grant_id]=1 for exactly one cycle, then move to WAIT_BUSY.
REQ-020 SHALL leave the outputs of the first grant one clock after req rises in IDLE; uart_send and ack are high in the following cycle.
REQ-021 SHALL, in WAIT_BUSY, move to WAIT_IDLE on uart_busy=1.
REQ-022 SHALL, if uart_busy is still 0 after 8 cycles in WAIT_BUSY, pulse start_err for one cycle, move to IDLE and update last_grant.
REQ-023 SHALL, in WAIT_IDLE, move to IDLE on uart_busy=0 and set last_grant=grant_id.
REQ-024 SHALL hold uart_d_in and uart_p_sel stable from SEND until the next grant.
REQ-025 SHALL ignore req changes outside IDLE; a req dropped after latch does not cancel the transfer.
REQ-026 SHALL treat a requester that keeps req high after ack as a new request, arbitrated in the next IDLE.
REQ-027 SHALL wrap the round-robin pointer from 3 to 0.
REQ-028 SHALL never assert more than one ack bit in any cycle.

Reset
REQ-029 SHALL, on reset high, immediately set the state to IDLE and force the following: ack=0, uart_send=0, uart_d_in=0, uart_p_sel=0, grant_id=0, active=0, start_err=0, last_grant=3.
REQ-030 SHALL, on reset mid-transfer, issue no ack and no uart_send afterwards for the abandoned byte.

Configuration
REQ-031 SHALL support the macro UART_ARB_FIXED_PRI_EN; when it is defined, arbitration is fixed priority, with req[0] highest and req[3] lowest, and last_grant is unused.
REQ-032 SHALL, when UART_ARB_FIXED_PRI_EN is undefined, use round-robin as in REQ-017.

Verification
REQ-033 SHALL cover: req=4'b0001, req_data[7:0]=8'hFF, psel=1, busy high 3 cycles after send for 20 cycles -> uart_d_in=8'hFF, uart_p_sel=1, one uart_send, ack=4'b0001, return to IDLE.
REQ-034 SHALL cover: req=4'b1111 held, with distinct bytes 8'hA0 to 8'hA3 -> grants in order 0,1,2,3,0 (round-robin); with UART_ARB_FIXED_PRI_EN, 0 is granted repeatedly.
REQ-035 SHALL cover: uart_busy held 0 after send -> start_err pulses 8 cycles after WAIT_BUSY entry, active drops, and the next request is served.
REQ-036 SHALL cover: reset asserted during WAIT_IDLE -> all outputs 0 in that cycle, no ack afterwards, and after release req=4'b0100 is granted with grant_id=2.
REQ-037 SHALL cover: req[1] dropped one cycle after latch -> the transfer completes and ack[1] still pulses once.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - four-requester arbiter feeding one UART transmitter.
// Define UART_ARB_FIXED_PRI_EN for fixed priority (req[0] highest); default is round-robin.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_psel,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      uart_send,
  output logic [DATA_W-1:0]         uart_d_in,
  output logic                      uart_p_sel,
  input  logic                      uart_busy,
  output logic [1:0]                grant_id,
  output logic                      active,
  output logic                      start_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] wb_cnt;
  logic       wb_timeout;
  logic [1:0] win_id;
  logic       win_vld;

`ifndef UART_ARB_FIXED_PRI_EN
  logic [1:0] last_grant;
  logic [1:0] cand;
`endif

  // Winner selection; the last hit in the loop carries the highest priority.
  always_comb begin
    win_id  = 2'd0;
    win_vld = 1'b0;
`ifdef UART_ARB_FIXED_PRI_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_id  = 2'(i);
        win_vld = 1'b1;
      end
    end
`else
    cand = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (req[cand]) begin
        win_id  = cand;
        win_vld = 1'b1;
      end
    end
`endif
  end

  assign wb_timeout = (state == WAIT_BUSY) && !uart_busy && (wb_cnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    uart_send = 1'b0;
    ack       = '0;
    active    = 1'b1;
    case (state)
      IDLE: begin
        active = 1'b0;
        if (win_vld) state_nxt = SEND;
      end
      SEND: begin
        uart_send     = 1'b1;
        ack[grant_id] = 1'b1;
        state_nxt     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (uart_busy)       state_nxt = WAIT_IDLE;
        else if (wb_timeout) state_nxt = IDLE;
      end
      WAIT_IDLE: begin
        if (!uart_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched byte/parity stay put until the next grant, even across a timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uart_d_in  <= '0;
      uart_p_sel <= 1'b0;
      grant_id   <= 2'd0;
      start_err  <= 1'b0;
      wb_cnt     <= 3'd0;
`ifndef UART_ARB_FIXED_PRI_EN
      last_grant <= 2'd3;
`endif
    end else begin
      start_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            uart_d_in  <= req_data[win_id*DATA_W +: DATA_W];
            uart_p_sel <= req_psel[win_id];
            grant_id   <= win_id;
          end
        end
        SEND: wb_cnt <= 3'd0;
        WAIT_BUSY: begin
          if (!uart_busy) begin
            if (wb_timeout) begin
              start_err <= 1'b1;
`ifndef UART_ARB_FIXED_PRI_EN
              last_grant <= grant_id;
`endif
            end else begin
              wb_cnt <= wb_cnt + 3'd1;
            end
          end
        end
        WAIT_IDLE: begin
`ifndef UART_ARB_FIXED_PRI_EN
          if (!uart_busy) last_grant <= grant_id;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_psel;
  logic [3:0]  ack;
  logic        uart_send;
  logic [7:0]  uart_d_in;
  logic        uart_p_sel;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        start_err;

  int total = 0;
  int bad   = 0;
  logic model_en;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       psel;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_psel(req_psel),
    .ack(ack), .uart_send(uart_send), .uart_d_in(uart_d_in), .uart_p_sel(uart_p_sel),
    .uart_busy(uart_busy), .grant_id(grant_id), .active(active), .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] data, input logic psel);
    exp_t e;
    e.id = id; e.data = data; e.psel = psel;
    exp_q.push_back(e);
  endtask

  // UART stand-in: goes busy 3 cycles after a send strobe, stays busy 20 cycles.
  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uart_send && model_en && !reset) begin
        repeat (3) @(negedge clk);
        uart_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (reset) break;
        end
        uart_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (uart_send || ack != 4'd0)) begin
        chk("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_send: ack=%b send=%b with no transfer pending", ack, uart_send);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("send_strobe", 32'(uart_send), 32'd1);
          chk("send_ack", 32'(ack), 32'(4'b0001 << e.id));
          chk("send_grant", 32'(grant_id), 32'(e.id));
          chk("send_data", 32'(uart_d_in), 32'(e.data));
          chk("send_psel", 32'(uart_p_sel), 32'(e.psel));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (active && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(active), 32'd0);
  endtask

  task automatic send_one(input logic [1:0] id, input logic [7:0] data, input logic psel);
    int n;
    @(negedge clk);
    req_data[id*8 +: 8] = data;
    req_psel[id] = psel;
    req[id] = 1'b1;
    push(id, data, psel);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[id] && n < 100);
    chk("send_one_ack_seen", 32'(ack[id]), 32'd1);
    req[id] = 1'b0;
    wait_idle("send_one_idle");
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1; req = '0; req_data = '0; req_psel = '0; model_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_send", 32'(uart_send), 32'd0);
    chk("rst_d_in", 32'(uart_d_in), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_start_err", 32'(start_err), 32'd0);
    reset = 1'b0;

    // Single request, latency of grant and stable byte afterwards
    @(negedge clk);
    req_data[7:0] = 8'hFF; req_psel = 4'b0001; req = 4'b0001;
    push(2'd0, 8'hFF, 1'b1);
    @(negedge clk);
    chk("lat_send", 32'(uart_send), 32'd1);
    chk("lat_ack", 32'(ack), 32'b0001);
    req = 4'b0000;
    wait_idle("t1_idle");
    chk("t1_hold_data", 32'(uart_d_in), 32'hFF);
    chk("t1_hold_psel", 32'(uart_p_sel), 32'd1);

    // All four requesting: round-robin order from a fresh reset
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    req_data = 32'hA3A2A1A0; req_psel = 4'b1010;
`ifdef UART_ARB_FIXED_PRI_EN
    for (int i = 0; i < 5; i++) push(2'd0, 8'hA0, 1'b0);
`else
    push(2'd0, 8'hA0, 1'b0); push(2'd1, 8'hA1, 1'b1); push(2'd2, 8'hA2, 1'b0);
    push(2'd3, 8'hA3, 1'b1); push(2'd0, 8'hA0, 1'b0);
`endif
    req = 4'b1111;
    cnt = 0; n = 0;
    while (cnt < 5 && n < 400) begin
      @(negedge clk);
      n++;
      if (ack != 4'd0) cnt++;
    end
    req = 4'b0000;
    chk("rr_ack_count", 32'(cnt), 32'd5);
    wait_idle("rr_idle");

    // UART never goes busy: start_err timeout
    model_en = 1'b0;
    @(negedge clk);
    req_data[23:16] = 8'h5A; req_psel[2] = 1'b1; req = 4'b0100;
    push(2'd2, 8'h5A, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!uart_send && n < 50);
    req = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) chk("start_err_early", 32'(start_err), 32'd0);
      if (i == 9) begin
        chk("start_err_pulse", 32'(start_err), 32'd1);
        chk("start_err_active", 32'(active), 32'd0);
      end
      if (i == 10) chk("start_err_one_cycle", 32'(start_err), 32'd0);
    end
    model_en = 1'b1;
    send_one(2'd3, 8'h3C, 1'b1);

    // Request dropped right after latch still completes once
    @(negedge clk);
    req_data[15:8] = 8'h71; req_psel[1] = 1'b0; req = 4'b0010;
    push(2'd1, 8'h71, 1'b0);
    @(posedge clk);
    #1 req = 4'b0000;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[1]) cnt++;
    end
    chk("drop_ack_once", 32'(cnt), 32'd1);
    wait_idle("drop_idle");

    // Reset while the UART is busy
    @(negedge clk);
    req_data[7:0] = 8'h96; req_psel[0] = 1'b1; req = 4'b0001;
    push(2'd0, 8'h96, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[0] && n < 50);
    req = 4'b0000;
    n = 0;
    while (!uart_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("pre_rst_active", 32'(active), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_send", 32'(uart_send), 32'd0);
    chk("mid_rst_d_in", 32'(uart_d_in), 32'd0);
    chk("mid_rst_psel", 32'(uart_p_sel), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    chk("mid_rst_active", 32'(active), 32'd0);
    chk("mid_rst_start_err", 32'(start_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack != 4'd0 || uart_send) cnt++;
    end
    chk("post_rst_quiet", 32'(cnt), 32'd0);
    send_one(2'd2, 8'h5C, 1'b0);
    chk("post_rst_grant", 32'(grant_id), 32'd2);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
